// File: rtl/atm_txn_ctrl.sv
// ATM session and transaction initiator for the balance unit.
// PIN login, one strobed request at a time, result check and lockout.
module atm_txn_ctrl #(
  parameter logic [15:0] PIN       = 16'h1234,
  parameter int          MAX_TRIES = 3,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic        card_in,
  input  logic        pin_valid,
  input  logic [15:0] pin_in,
  input  logic        op_valid,
  input  logic        op_sel,
  input  logic [6:0]  amount,
  input  logic        cancel,
  input  logic [7:0]  balance,
  output logic        dep_en,
  output logic        with_en,
  output logic [6:0]  price,
  output logic        pin_err,
  output logic        txn_ok,
  output logic        txn_fail,
  output logic [1:0]  fail_code,
  output logic        locked,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN_WAIT = 3'd1,
    MENU     = 3'd2,
    ISSUE    = 3'd3,
    CHECK    = 3'd4,
    RESULT   = 3'd5,
    LOCK     = 3'd7
  } state_t;

  localparam logic [7:0] TLIM  = 8'(TIMEOUT - 1);
  localparam logic [2:0] TRIES = 3'(MAX_TRIES);

  state_t      state;
  logic [2:0]  tries;
  logic [7:0]  timer;
  logic        card_q;
  logic        op_q;
  logic [6:0]  amt_q;
  logic [7:0]  snap;
  logic [8:0]  sum;
  logic        dep_good;
  logic        wd_good;
  logic        good;

  // balance already reflects the strobe by the time CHECK samples it
  assign sum      = {1'b0, snap} + {2'b00, amt_q};
  assign dep_good = (sum <= 9'd255) && (balance == sum[7:0]);
  assign wd_good  = ({1'b0, amt_q} < snap) &&
                    (balance == snap - {1'b0, amt_q});
  assign good     = op_q ? dep_good : wd_good;
  assign state_o  = state;

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      tries     <= 3'd0;
      timer     <= 8'd0;
      card_q    <= 1'b0;
      op_q      <= 1'b0;
      amt_q     <= 7'd0;
      snap      <= 8'd0;
      dep_en    <= 1'b0;
      with_en   <= 1'b0;
      price     <= 7'd0;
      pin_err   <= 1'b0;
      txn_ok    <= 1'b0;
      txn_fail  <= 1'b0;
      fail_code <= 2'b00;
      locked    <= 1'b0;
    end else begin
      card_q    <= card_in;
      dep_en    <= 1'b0;
      with_en   <= 1'b0;
      price     <= 7'd0;
      pin_err   <= 1'b0;
      txn_ok    <= 1'b0;
      txn_fail  <= 1'b0;
      fail_code <= 2'b00;
      timer     <= 8'd0;
      unique case (state)
        IDLE: begin
          if (card_in && !card_q) begin
            state <= PIN_WAIT;
            tries <= 3'd0;
          end
        end
        PIN_WAIT: begin
          if (!card_in || cancel) begin
            state <= IDLE;
          end else if (pin_valid && pin_in == PIN) begin
            state <= MENU;
          end else if (pin_valid) begin
            pin_err <= 1'b1;
            tries   <= tries + 3'd1;
            if (tries + 3'd1 == TRIES) begin
              state  <= LOCK;
              locked <= 1'b1;
            end
          end else if (timer == TLIM) begin
            state     <= RESULT;
            txn_fail  <= 1'b1;
            fail_code <= 2'b11;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        MENU: begin
          if (!card_in || cancel) begin
            state <= IDLE;
          end else if (op_valid && amount == 7'd0) begin
            state     <= RESULT;
            txn_fail  <= 1'b1;
            fail_code <= 2'b00;
          end else if (op_valid) begin
            op_q    <= op_sel;
            amt_q   <= amount;
            snap    <= balance;
            price   <= amount;
            dep_en  <= op_sel;
            with_en <= !op_sel;
            state   <= ISSUE;
          end else if (timer == TLIM) begin
            state     <= RESULT;
            txn_fail  <= 1'b1;
            fail_code <= 2'b11;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ISSUE: state <= CHECK;
        CHECK: begin
          txn_ok    <= good;
          txn_fail  <= !good;
          fail_code <= good ? 2'b00 : (op_q ? 2'b10 : 2'b01);
          state     <= RESULT;
        end
        RESULT: begin
          if (txn_fail && fail_code == 2'b11) state <= IDLE;
          else if (card_in)                   state <= MENU;
          else                                state <= IDLE;
        end
        LOCK: locked <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
